// File: rtl/rv_instr_encoder_if.sv
// Micro-op in / instruction-out bundle for rv_instr_encoder.
// master drives micro-ops and consumes words; slave is the encoder.
interface rv_instr_encoder_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op_class;
  logic [3:0]      alu_op;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [19:0]     imm;
  logic            pc_load;
  logic [XLEN-1:0] pc_load_val;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] PC;
  logic            err;

  modport master (
    output in_valid, op_class, alu_op,
    output rd, rs1, rs2, imm,
    output pc_load, pc_load_val,
    output instr_ready,
    input  in_ready, instr_valid,
    input  Instr, PC, err
  );

  modport slave (
    input  in_valid, op_class, alu_op,
    input  rd, rs1, rs2, imm,
    input  pc_load, pc_load_val,
    input  instr_ready,
    output in_ready, instr_valid,
    output Instr, PC, err
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32I micro-op encoder feeding a PC-tagged FIFO.
// Define RV_INSTR_ENC_ERR_EN to drop illegal micro-ops and pulse err.
module rv_instr_encoder #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  rv_instr_encoder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        is_shift;
  logic [31:0] enc;
  logic        drop;

  always_comb begin
    f3       = 3'b000;
    f7       = 7'b0000000;
    is_shift = 1'b0;
    case (bus.alu_op)
      4'b0000: f3 = 3'b000;
      4'b0001: begin
        f3 = 3'b000;
        f7 = F7_ALT;
      end
      4'b0010: begin
        f3       = 3'b001;
        is_shift = 1'b1;
      end
      4'b0011: f3 = 3'b010;
      4'b0100: f3 = 3'b011;
      4'b0101: f3 = 3'b100;
      4'b0110: begin
        f3       = 3'b101;
        f7       = F7_ALT;
        is_shift = 1'b1;
      end
      4'b0111: begin
        f3       = 3'b101;
        is_shift = 1'b1;
      end
      4'b1000: f3 = 3'b110;
      4'b1001: f3 = 3'b111;
      // Out-of-range codes pass their low bits straight through
      default: f3 = bus.alu_op[2:0];
    endcase
  end

  always_comb begin
    enc = 32'h0000_0013;
    unique case (1'b1)
      (bus.op_class == 2'b00): begin
        if (is_shift)
          enc = {f7, bus.imm[4:0], bus.rs1,
                 f3, bus.rd, OPC_OPIMM};
        else
          enc = {bus.imm[11:0], bus.rs1,
                 f3, bus.rd, OPC_OPIMM};
      end
      (bus.op_class == 2'b01):
        enc = {f7, bus.rs2, bus.rs1,
               f3, bus.rd, OPC_OP};
      (bus.op_class == 2'b10):
        enc = {bus.imm, bus.rd, OPC_LUI};
      (bus.op_class == 2'b11):
        enc = {bus.imm, bus.rd, OPC_AUIPC};
      default: enc = 32'h0000_0013;
    endcase
  end

  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic empty;
  logic full;
  logic accept;
  logic push;
  logic pop;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !drop;
  assign pop    = !empty && bus.instr_ready;

`ifdef RV_INSTR_ENC_ERR_EN
  logic illegal;
  logic err_q, err_d;

  assign illegal = !bus.op_class[1] &&
                   ((bus.alu_op > 4'd9) ||
                    (bus.op_class == 2'b00 &&
                     bus.alu_op == 4'b0001));
  assign drop  = illegal;
  assign err_d = accept && illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign drop    = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    // A load flushes everything, including a pop this cycle
    if (bus.pc_load) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      pc_d     = bus.pc_load_val;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        pc_d     = pc_q + PC_STEP;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pc_q     <= RESET_PC;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= XLEN'(enc);
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign bus.in_ready    = !full && !bus.pc_load;
  assign bus.instr_valid = !empty;
  assign bus.Instr = empty ? NOP  : instr_mem_q[rd_ptr_q];
  assign bus.PC    = empty ? pc_q : pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder.
// Inputs driven and outputs sampled on the falling edge.
module tb_rv_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  rv_instr_encoder_if #(.XLEN(32)) bus ();

  rv_instr_encoder #(
    .XLEN(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic uop(input logic [1:0]  cls,
                     input logic [3:0]  op,
                     input logic [4:0]  d,
                     input logic [4:0]  s1,
                     input logic [4:0]  s2,
                     input logic [19:0] im);
    bus.op_class = cls;
    bus.alu_op   = op;
    bus.rd       = d;
    bus.rs1      = s1;
    bus.rs2      = s2;
    bus.imm      = im;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] fill_exp [4];

  initial begin
    fill_exp[0] = 32'h0010_0093;
    fill_exp[1] = 32'h0020_0113;
    fill_exp[2] = 32'h0030_0193;
    fill_exp[3] = 32'h0040_0213;

    bus.in_valid    = 1'b0;
    bus.op_class    = '0;
    bus.alu_op      = '0;
    bus.rd          = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.imm         = '0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.Instr, 32'h0000_0013);
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // addi x1, x0, 5
    uop(2'b00, 4'b0000, 5'd1, 5'd0, 5'd0, 20'd5);
    chk("addi_valid", 32'(bus.instr_valid), 32'd1);
    chk("addi_instr", bus.Instr, 32'h0050_0093);
    chk("addi_pc", bus.PC, 32'h0);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("pop_empty", 32'(bus.instr_valid), 32'd0);
    chk("pop_nop", bus.Instr, 32'h0000_0013);
    chk("empty_pc", bus.PC, 32'h4);

    // sub then srai, consumer always ready
    do_reset();
    bus.instr_ready = 1'b1;
    uop(2'b01, 4'b0001, 5'd3, 5'd1, 5'd2, 20'd0);
    chk("sub_instr", bus.Instr, 32'h4020_81B3);
    chk("sub_pc", bus.PC, 32'h0);
    uop(2'b00, 4'b0110, 5'd4, 5'd3, 5'd0, 20'd2);
    chk("srai_instr", bus.Instr, 32'h4021_D213);
    chk("srai_pc", bus.PC, 32'h4);
    tick();
    chk("drain2_valid", 32'(bus.instr_valid), 32'd0);
    chk("drain2_pc", bus.PC, 32'h8);

    uop(2'b10, 4'b0000, 5'd5, 5'd0, 5'd0, 20'h12345);
    chk("lui_instr", bus.Instr, 32'h1234_52B7);
    chk("lui_pc", bus.PC, 32'h8);
    uop(2'b11, 4'b0101, 5'd6, 5'd7, 5'd8, 20'hABCDE);
    chk("auipc_instr", bus.Instr, 32'hABCD_E317);
    chk("auipc_pc", bus.PC, 32'hC);
    uop(2'b01, 4'b1001, 5'd7, 5'd8, 5'd9, 20'd0);
    chk("and_instr", bus.Instr, 32'h0094_73B3);
    uop(2'b00, 4'b0010, 5'd10, 5'd11, 5'd0, 20'h00FFF);
    chk("slli_instr", bus.Instr, 32'h01F5_9513);
    chk("slli_pc", bus.PC, 32'h14);
    tick();
    chk("drain3_valid", 32'(bus.instr_valid), 32'd0);

    // fill to DEPTH with consumer stalled
    do_reset();
    bus.instr_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      uop(2'b00, 4'b0000, 5'(k), 5'd0, 5'd0, 20'(k));
      chk($sformatf("fill_rdy%0d", k),
          32'(bus.in_ready), (k == 4) ? 32'd0 : 32'd1);
    end
    bus.rd       = 5'd31;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("full_rdy", 32'(bus.in_ready), 32'd0);
    chk("full_head_pc", bus.PC, 32'h0);
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_instr%0d", k),
          bus.Instr, fill_exp[k]);
      chk($sformatf("drain_pc%0d", k),
          bus.PC, 32'(4 * k));
      tick();
      if (k == 0)
        chk("rdy_after_pop", 32'(bus.in_ready), 32'd1);
    end
    chk("drain4_valid", 32'(bus.instr_valid), 32'd0);
    chk("drain4_pc", bus.PC, 32'h10);
    bus.instr_ready = 1'b0;

    // pc_load with two entries buffered
    uop(2'b00, 4'b0000, 5'd1, 5'd0, 5'd0, 20'd1);
    uop(2'b00, 4'b0000, 5'd2, 5'd0, 5'd0, 20'd2);
    chk("pre_load_pc", bus.PC, 32'h10);
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 32'h100;
    bus.instr_ready = 1'b1;
    #1;
    chk("load_rdy", 32'(bus.in_ready), 32'd0);
    tick();
    bus.pc_load     = 1'b0;
    bus.instr_ready = 1'b0;
    chk("load_valid", 32'(bus.instr_valid), 32'd0);
    chk("load_pc", bus.PC, 32'h100);
    uop(2'b10, 4'b0000, 5'd5, 5'd0, 5'd0, 20'h12345);
    chk("post_load_pc", bus.PC, 32'h100);
    chk("post_load_instr", bus.Instr, 32'h1234_52B7);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // sub under OP-IMM
    uop(2'b00, 4'b0001, 5'd1, 5'd0, 5'd0, 20'd5);
`ifdef RV_INSTR_ENC_ERR_EN
    chk("ill_err", 32'(bus.err), 32'd1);
    chk("ill_valid", 32'(bus.instr_valid), 32'd0);
    chk("ill_pc", bus.PC, 32'h104);
    tick();
    chk("ill_err_off", 32'(bus.err), 32'd0);
    uop(2'b00, 4'b0000, 5'd1, 5'd0, 5'd0, 20'd5);
    chk("ill_next_pc", bus.PC, 32'h104);
    chk("ill_next_instr", bus.Instr, 32'h0050_0093);
`else
    chk("ill_err", 32'(bus.err), 32'd0);
    chk("ill_valid", 32'(bus.instr_valid), 32'd1);
    chk("ill_instr", bus.Instr, 32'h0050_0093);
    chk("ill_pc", bus.PC, 32'h104);
`endif
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;

    // PC wrap at the top of the address space
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 32'hFFFF_FFFC;
    tick();
    bus.pc_load = 1'b0;
    uop(2'b00, 4'b0000, 5'd1, 5'd0, 5'd0, 20'd1);
    uop(2'b00, 4'b0000, 5'd2, 5'd0, 5'd0, 20'd2);
    chk("wrap_pc0", bus.PC, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("wrap_pc1", bus.PC, 32'h0);
    chk("wrap_instr1", bus.Instr, 32'h0020_0113);

    // asynchronous reset with an entry still buffered
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_pc", bus.PC, 32'h0);
    chk("arst_instr", bus.Instr, 32'h0000_0013);
    @(negedge clk);
    reset = 1'b0;
    chk("arst_rdy", 32'(bus.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
Converts symbolic micro-ops (operation class, register indices, immediate, ALU operation code) into RV32I instruction words and buffers them in a small FIFO. It presents the words, each with its PC, to the single-cycle core's control/datapath over a valid/ready handshake. It is the producer side of the Instr/PC interface and is used as the instruction source in self-checking benches and for program injection. The ALU operation codes are the same 4-bit AluCtrl codes the core's control decoder produces, so each instruction can round-trip from encoder to decoder.

Parameters:
XLEN, 32, width of Instr and PC
DEPTH, 4, FIFO entries; must be a power of two and at least 2
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  a micro-op is presented
in_ready  output  1  encoder can accept a micro-op
op_class  input  2  00 OP-IMM, 01 OP, 10 LUI, 11 AUIPC
alu_op  input  4  AluCtrl code: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 sra, 0111 srl, 1000 or, 1001 and
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2 (OP class only)
imm  input  20  immediate; [11:0] for OP-IMM, [4:0] as shamt for shifts, [19:0] for LUI/AUIPC
pc_load  input  1  flush the FIFO and load the PC
pc_load_val  input  XLEN  new PC value
instr_valid  output  1  Instr/PC hold a valid instruction
instr_ready  input  1  consumer takes the instruction
Instr  output  XLEN  encoded instruction
PC  output  XLEN  address of Instr
err  output  1  one-cycle pulse when an illegal micro-op is dropped

Behaviour:
- Reset values: in_ready=1, instr_valid=0, Instr=32'h0000_0013 (NOP), PC=RESET_PC, err=0, FIFO empty.
- Opcodes: OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111.
- funct3 by alu_op: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
- funct7: 0100000 for sub and sra; 0000000 otherwise.
- I-type encoding: Instr = {imm[11:0], rs1, funct3, rd, opcode}.
- I-type shift encoding: Instr = {funct7, imm[4:0], rs1, funct3, rd, opcode}; imm[11:5] is ignored.
- R-type encoding: Instr = {funct7, rs2, rs1, funct3, rd, opcode}.
- U-type encoding: Instr = {imm[19:0], rd, opcode}; alu_op and rs1/rs2 are ignored.
- Illegal micro-ops: sub under OP-IMM; any alu_op code above 1001 under OP-IMM or OP.
- Input handshake: the micro-op is accepted on a cycle with in_valid && in_ready. The encoded word is written into the FIFO at that edge.
- Latency: a word accepted into an empty FIFO at edge N shows instr_valid=1 after edge N. There is no same-cycle bypass.
- in_ready = !full && !pc_load. When full, no push occurs even if a pop happens in the same cycle.
- Output handshake: a pop occurs on instr_valid && instr_ready. The next entry or NOP is presented after that edge.
- Each FIFO entry carries its own PC. The PC counter increments by 4 (mod 2^XLEN) per accepted push, so the entry after 0xFFFF_FFFC is 0x0000_0000.
- While empty: instr_valid=0, Instr=NOP, PC=next PC to be assigned.
- Push and pop in the same cycle with the FIFO neither full nor empty: occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- pc_load: at the next edge the FIFO is emptied and the PC counter is set to pc_load_val. Any pop in that cycle is discarded and instr_valid=0 on the following cycle.
- Reset asserted mid-transfer: all state returns to reset values immediately. Buffered entries are lost.

Optional Feature:
Macro RV_INSTR_ENC_ERR_EN.
- Defined: illegal micro-ops are accepted (in_ready behaves normally) but not written to the FIFO. The PC is not advanced, and err pulses high for one cycle.
- Undefined: no legality check. Illegal micro-ops are encoded with the normal rules (sub under OP-IMM encodes as addi; funct3/funct7 use the low bits as-is). err is tied to 0.

Test Plan:
- Reset, then push OP-IMM add, rd=1, rs1=0, imm=5 -> one cycle later instr_valid=1, Instr=32'h0050_0093, PC=0.
- Push OP sub, rd=3, rs1=1, rs2=2, then OP-IMM sra, rd=4, rs1=3, imm=2, with instr_ready=1 -> Instr=32'h4020_81B3 at PC=0, then 32'h4021_D213 at PC=4.
- Push LUI rd=5, imm=20'h12345 -> Instr=32'h1234_52B7.
- Hold instr_ready=0 and push DEPTH micro-ops -> in_ready=0 after the fourth push; a fifth in_valid is not accepted. Raise instr_ready -> words drain in order with PCs 0,4,8,12; in_ready returns after the first pop.
- With 2 entries buffered, pulse pc_load with pc_load_val=32'h100 -> instr_valid=0 next cycle; the next push is output with PC=32'h100.
- With RV_INSTR_ENC_ERR_EN defined, push OP-IMM sub -> err=1 for one cycle, FIFO unchanged, next legal push gets an unchanged PC. With the macro undefined, the same push gives Instr with funct3=000, funct7 field clear (addi).
